// File: rtl/jk_driver_if.sv
// Target handshake plus command/feedback bus between jk_driver and a JK flip-flop bank.
interface jk_driver_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] tgt;
    logic         tgt_valid;
    logic         tgt_ready;
    logic [N-1:0] q_fb;
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         en;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output tgt, tgt_valid, q_fb,
        input  tgt_ready, j, k, en, busy, done, err
    );

    modport slave (
        input  tgt, tgt_valid, q_fb,
        output tgt_ready, j, k, en, busy, done, err
    );
endinterface

// File: rtl/jk_driver.sv
// Drives an enable-gated JK flip-flop bank to a requested word using the JK
// excitation table, verifying the bank outputs and retrying on mismatch.
module jk_driver #(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          USE_TOGGLE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    jk_driver_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, CMD, PULSE, CHECK} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   tgt_q, tgt_d;
    logic [CW-1:0]  att_q, att_d;
    logic [N-1:0]   j_q, j_d, k_q, k_d;
    logic           en_q, en_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic [N-1:0]   diff_c, set_c, clr_c;

    // Per-bit excitation: set/reset by default, toggle when configured.
    always_comb begin
        diff_c = bus.q_fb ^ tgt_q;
        if (USE_TOGGLE) begin
            set_c = diff_c;
            clr_c = diff_c;
        end else begin
            set_c = diff_c & tgt_q;
            clr_c = diff_c & ~tgt_q;
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        att_d   = att_q;
        j_d     = '0;
        k_d     = '0;
        en_d    = 1'b0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ready_q && bus.tgt_valid) begin
                    tgt_d   = bus.tgt;
                    err_d   = 1'b0;
                    att_d   = CW'(1);
                    ready_d = 1'b0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (|diff_c) begin
                    j_d     = set_c;
                    k_d     = clr_c;
                    en_d    = 1'b1;
                    state_d = PULSE;
                end else begin
                    state_d = CHECK;
                end
            end
            PULSE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (diff_c == '0) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else if (att_q < CW'(MAX_RETRY)) begin
                    att_d   = att_q + CW'(1);
                    state_d = CMD;
                end else begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            att_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            att_q   <= att_d;
            j_q     <= j_d;
            k_q     <= k_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.tgt_ready = ready_q;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.en        = en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_jk_driver.sv
// Directed bench for jk_driver: two instances (set/reset and toggle) each
// driving a behavioural JK bank model.
module tb_jk_driver;
    logic clk;
    logic reset_n;

    jk_driver_if #(.N(4)) bus1 ();
    jk_driver_if #(.N(4)) bus2 ();

    jk_driver #(.N(4), .MAX_RETRY(3), .USE_TOGGLE(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave)
    );
    jk_driver #(.N(4), .MAX_RETRY(3), .USE_TOGGLE(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
    );

    logic [3:0] bank1, bank2, ld1_val, ld2_val, stuck1;
    logic       ld1, ld2;
    int         en_cnt1, done_cnt1;
    int         n_checks, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK bank models: q+ = j&~q | ~k&q when enabled.
    always @(posedge clk) begin
        if (ld1) bank1 <= ld1_val;
        else if (bus1.en) bank1 <= (bus1.j & ~bank1) | (~bus1.k & bank1);
        if (ld2) bank2 <= ld2_val;
        else if (bus2.en) bank2 <= (bus2.j & ~bank2) | (~bus2.k & bank2);
        if (bus1.en) en_cnt1 <= en_cnt1 + 1;
        if (bus1.done) done_cnt1 <= done_cnt1 + 1;
    end

    assign bus1.q_fb = bank1 & ~stuck1;
    assign bus2.q_fb = bank2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load1(input logic [3:0] v);
        ld1_val = v; ld1 = 1'b1; step(); ld1 = 1'b0;
    endtask

    task automatic load2(input logic [3:0] v);
        ld2_val = v; ld2 = 1'b1; step(); ld2 = 1'b0;
    endtask

    // Steps until bus1.done, returning the cycle index after E0 (0 on timeout).
    task automatic wait_done1(input int limit, output int at);
        at = 0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus1.done && at == 0) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int at, en0, d0;
        n_checks = 0; n_fail = 0;
        en_cnt1 = 0; done_cnt1 = 0;
        reset_n = 1'b0;
        ld1 = 1'b0; ld2 = 1'b0; ld1_val = '0; ld2_val = '0; stuck1 = '0;
        bus1.tgt = '0; bus1.tgt_valid = 1'b0;
        bus2.tgt = '0; bus2.tgt_valid = 1'b0;
        @(negedge clk);
        load1(4'b0000);
        load2(4'b0000);
        check("reset_outs", 32'({bus1.tgt_ready, bus1.j, bus1.k, bus1.en, bus1.busy, bus1.done, bus1.err}), 32'h0);

        // Test 1: set/reset command 0000 -> 1010
        reset_n = 1'b1;
        #1 check("ready_before_edge", 32'(bus1.tgt_ready), 32'h0);
        step();
        check("ready_after_release", 32'(bus1.tgt_ready), 32'h1);
        bus1.tgt = 4'b1010; bus1.tgt_valid = 1'b1;
        en0 = en_cnt1;
        step();                                  // E0
        bus1.tgt_valid = 1'b0;
        check("t1_e0_ready_busy", 32'({bus1.tgt_ready, bus1.busy, bus1.en}), 32'b010);
        step();                                  // E1
        check("t1_e1_cmd", 32'({bus1.en, bus1.j, bus1.k}), 32'b1_1010_0000);
        step();                                  // E2
        check("t1_e2_en_off", 32'({bus1.en, bus1.busy, bus1.done}), 32'b010);
        check("t1_bank", 32'(bus1.q_fb), 32'hA);
        step();                                  // E3
        check("t1_e3_done", 32'({bus1.done, bus1.tgt_ready, bus1.busy, bus1.err}), 32'b1100);
        check("t1_en_count", 32'(en_cnt1 - en0), 32'd1);
        step();
        check("t1_done_pulse", 32'(bus1.done), 32'h0);

        // Test 2: toggle instance, 1100 -> 0110
        load2(4'b1100);
        bus2.tgt = 4'b0110; bus2.tgt_valid = 1'b1;
        step();                                  // E0
        bus2.tgt_valid = 1'b0;
        step();                                  // E1
        check("t2_e1_cmd", 32'({bus2.en, bus2.j, bus2.k}), 32'b1_1010_1010);
        step();
        step();                                  // E3
        check("t2_e3_done", 32'({bus2.done, bus2.tgt_ready}), 32'b11);
        check("t2_bank", 32'(bus2.q_fb), 32'h6);

        // Test 3: no differing bits -> no strobe, 3-cycle transaction
        load1(4'b0101);
        en0 = en_cnt1;
        bus1.tgt = 4'b0101; bus1.tgt_valid = 1'b1;
        step();                                  // E0
        bus1.tgt_valid = 1'b0;
        step();                                  // E1
        check("t3_e1", 32'({bus1.en, bus1.busy, bus1.done}), 32'b010);
        step();                                  // E2
        check("t3_e2_done", 32'({bus1.done, bus1.tgt_ready, bus1.busy}), 32'b110);
        check("t3_no_strobe", 32'(en_cnt1 - en0), 32'd0);

        // Test 4: bit 0 stuck at 0 -> retries exhausted, err set at E9
        load1(4'b0000);
        stuck1 = 4'b0001;
        en0 = en_cnt1;
        bus1.tgt = 4'b0001; bus1.tgt_valid = 1'b1;
        step();                                  // E0
        bus1.tgt_valid = 1'b0;
        wait_done1(14, at);
        check("t4_done_cycle", 32'(at), 32'd9);
        check("t4_err", 32'({bus1.err, bus1.tgt_ready}), 32'b11);
        check("t4_strobes", 32'(en_cnt1 - en0), 32'd3);
        step();
        check("t4_err_sticky", 32'(bus1.err), 32'h1);
        bus1.tgt = 4'b0000; bus1.tgt_valid = 1'b1;
        step();                                  // E0 of next target
        bus1.tgt_valid = 1'b0;
        check("t4_err_cleared", 32'(bus1.err), 32'h0);
        wait_done1(12, at);
        check("t4b_done_cycle", 32'(at), 32'd2);
        stuck1 = 4'b0000;

        // Test 5: asynchronous reset during PULSE
        load1(4'b0000);
        bus1.tgt = 4'b1111; bus1.tgt_valid = 1'b1;
        step();                                  // E0
        bus1.tgt_valid = 1'b0;
        step();                                  // E1
        check("t5_strobe", 32'({bus1.en, bus1.j}), 32'b1_1111);
        d0 = done_cnt1;
        #1 reset_n = 1'b0;
        #1 check("t5_async_clear", 32'({bus1.en, bus1.j, bus1.k, bus1.busy}), 32'h0);
        step();
        step();
        check("t5_no_done", 32'(done_cnt1 - d0), 32'd0);
        check("t5_bank_untouched", 32'(bus1.q_fb), 32'h0);
        reset_n = 1'b1;
        step();
        check("t5_ready_release", 32'({bus1.tgt_ready, bus1.busy}), 32'b10);

        // Test 6: tgt_valid held with changing tgt; next accept exactly at E4
        bus1.tgt = 4'b0011; bus1.tgt_valid = 1'b1;
        step();                                  // E0
        bus1.tgt = 4'b1100;
        step();                                  // E1
        check("t6_cmd_latched", 32'({bus1.j, bus1.k}), 32'b0011_0000);
        bus1.tgt = 4'b1000;
        step();                                  // E2
        bus1.tgt = 4'b0111;
        step();                                  // E3
        check("t6_e3_done", 32'({bus1.done, bus1.tgt_ready, bus1.q_fb}), 32'b11_0011);
        bus1.tgt = 4'b0110;
        step();                                  // E4
        check("t6_e4_accept", 32'({bus1.tgt_ready, bus1.busy}), 32'b01);
        bus1.tgt_valid = 1'b0;
        bus1.tgt = 4'b1111;
        wait_done1(12, at);
        check("t6b_done_cycle", 32'(at), 32'd3);
        check("t6b_bank", 32'(bus1.q_fb), 32'h6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_driver.md
# jk_driver

Command generator that drives a bank of `N` enable-gated JK flip-flops to a requested target word. It takes a target over a valid/ready handshake and compares it with the live flip-flop outputs fed back on `q_fb`. It then issues one registered J/K/enable command using the JK excitation table and verifies the result. A failed check is retried up to `MAX_RETRY` attempts. The block sits on the write side of our JK register banks; the flip-flops themselves remain the receiving end.

## Interface
- `N`, default 4, width of the target word and of the driven flip-flop bank.
- `MAX_RETRY`, default 3, total command attempts before error; legal range is ≥1.
- `USE_TOGGLE`, default 0. At 0, changing bits use set/reset (J=1,K=0 / J=0,K=1). At 1, changing bits use toggle (J=K=1).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tgt`  in  N  requested flip-flop bank value.
- `tgt_valid`  in  1  `tgt` is valid.
- `tgt_ready`  out  1  block can accept a target.
- `q_fb`  in  N  current outputs of the driven flip-flop bank.
- `j`  out  N  J inputs of the bank.
- `k`  out  N  K inputs of the bank.
- `en`  out  1  bank enable, a one-cycle command strobe.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of each transaction.
- `err`  out  1  sticky flag: the last transaction exhausted its retries.

## Operation
- All outputs are registered.
- While `reset_n`=0, every output is 0 immediately: `tgt_ready`, `j`, `k`, `en`, `busy`, `done`, `err`. The state is IDLE and the attempt counter is 0.
- `tgt_ready` rises on the first `clk` edge after `reset_n` is released.
- There are four states: IDLE, CMD, PULSE and CHECK.
- **IDLE**, `tgt_ready`=1:
  - When `tgt_valid`=1 at an edge, the block latches `tgt` into an internal target register and clears `err`.
  - It also sets the attempt counter to 1, drops `tgt_ready`, and moves to CMD.
  - `tgt_valid` while `tgt_ready`=0 is ignored. Changes to `tgt` after acceptance have no effect.
- **CMD** computes a command per bit `i` from `q_fb[i]` and the latched target bit:
  - equal bits give j=0, k=0;
  - 0→1 gives j=1, k=0 (j=k=1 if `USE_TOGGLE`);
  - 1→0 gives j=0, k=1 (j=k=1 if `USE_TOGGLE`).
  - If any bit differs, the next edge registers `j`/`k`, sets `en`=1 and moves to PULSE.
  - If no bit differs, the next edge keeps j=k=en=0 and moves to CHECK, with no strobe issued.
- **PULSE**: the next edge clears `j`, `k` and `en` and moves to CHECK. `en` is therefore high for exactly one cycle.
- **CHECK**: at the next edge the block compares `q_fb` with the latched target.
  - Equal: pulse `done`, set `tgt_ready`=1, go to IDLE.
  - Unequal and attempts < `MAX_RETRY`: increment the attempt counter and go to CMD.
  - Unequal and attempts = `MAX_RETRY`: set `err`=1, pulse `done`, set `tgt_ready`=1, go to IDLE.
- The attempt counter is `$clog2(MAX_RETRY+1)` bits wide and never wraps.
- `err` holds until the next accepted target or reset.
- Reset asserted mid-transaction aborts it immediately:
  - `en` drops asynchronously;
  - no `done` pulse is generated;
  - the latched target is discarded.

## Timing
- Accept at edge E0. The strobe `en`=1 appears after E1, and the bank samples it at E2. `q_fb` is checked at E3. `done` is high during the cycle after E3, and `tgt_ready`=1 in that same cycle.
- The earliest next accept is E4, so the successful transaction period is 4 cycles.
- When no bits differ, `done` follows E2 and the transaction takes 3 cycles.
- Each retry adds 3 cycles (CMD, PULSE, CHECK).
- The worst case with `MAX_RETRY`=3 is `done` after E9.
- `done` and `en` are never high in the same cycle.
- `busy` = (state ≠ IDLE), registered, so it is high from the cycle after E0 through the CHECK cycle.

## Test plan
- Reset release with `q_fb`=0000, accept `tgt`=1010 → after E1: j=1010, k=0000, en=1 for one cycle; bank model reaches 1010; `done` pulse after E3; `err`=0.
- `USE_TOGGLE`=1, `q_fb`=1100, `tgt`=0110 → j=k=1010 during the strobe; bank reaches 0110; `done` after E3.
- `q_fb`=0101, `tgt`=0101 → `en` never asserted; `done` after E2; `tgt_ready` back in the same cycle.
- Bank model with bit 0 stuck at 0, `tgt`=0001, `MAX_RETRY`=3 → three `en` strobes; `err`=1 with `done` after E9; the next accepted target clears `err`.
- Pull `reset_n` low during PULSE → `en`, `j`, `k`, `busy` go to 0 without a clock edge; no `done`; `tgt_ready`=1 one edge after release.
- Hold `tgt_valid`=1 with a changing `tgt` throughout a transaction → only the value at E0 is applied; the next accept occurs exactly at E4.
